// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit saturating PHT with bimodal or gshare indexing.
// Prediction is combinational from if_pc; training, history and statistics update on resolve.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 32,
    parameter int GHR_BITS = 5,
    parameter int MODE     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     if_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [XLEN-1:0]     next_pc,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_misses
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    typedef logic [IDX-1:0]   idx_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    logic [ENTRIES-1:0]  valid;
    ctr_t                pht        [ENTRIES];
    tag_t                tag_mem    [ENTRIES];
    logic [XLEN-1:0]     target_mem [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [31:0]         branches;
    logic [31:0]         misses;

    idx_t lk_idx;
    tag_t lk_tag;
    idx_t lk_pht_idx;
    logic lk_hit;
    idx_t up_idx;
    tag_t up_tag;
    idx_t up_pht_idx;

    // Low PC bits are always zero for aligned fetch and take no part in indexing.
    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_ghr};

    function automatic idx_t pht_index(input idx_t pc_idx, input logic [GHR_BITS-1:0] hist);
        if (MODE == 1) return pc_idx ^ idx_t'(hist);
        else           return pc_idx;
    endfunction

    always_comb begin
        lk_idx      = if_pc[IDX+1:2];
        lk_tag      = if_pc[XLEN-1:IDX+2];
        lk_pht_idx  = pht_index(lk_idx, ghr);
        lk_hit      = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
        pred_taken  = lk_hit && pht[lk_pht_idx][1];
        pred_target = target_mem[lk_idx];
        next_pc     = pred_taken ? pred_target : if_pc + XLEN'(4);
        up_idx      = upd_pc[IDX+1:2];
        up_tag      = upd_pc[XLEN-1:IDX+2];
        // Training uses the history snapshot taken at prediction time, not the live GHR.
        up_pht_idx  = pht_index(up_idx, upd_ghr);
    end

    assign pred_ghr      = ghr;
    assign stat_branches = branches;
    assign stat_misses   = misses;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid    <= '0;
            ghr      <= '0;
            branches <= '0;
            misses   <= '0;
            for (int i = 0; i < ENTRIES; i++) pht[i] <= WEAK_NT;
        end else if (upd_valid) begin
            if (upd_taken && pht[up_pht_idx] != STRONG_T)
                pht[up_pht_idx] <= ctr_t'(pht[up_pht_idx] + 2'b01);
            else if (!upd_taken && pht[up_pht_idx] != STRONG_NT)
                pht[up_pht_idx] <= ctr_t'(pht[up_pht_idx] - 2'b01);
            if (upd_taken) valid[up_idx] <= 1'b1;
            ghr <= (ghr << 1) | GHR_BITS'(upd_taken);
            if (branches != 32'hFFFF_FFFF) branches <= branches + 32'd1;
            if (upd_mispredict && misses != 32'hFFFF_FFFF) misses <= misses + 32'd1;
        end
    end

    // NOTE: tag/target arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (reset && upd_valid && upd_taken) begin
            tag_mem[up_idx]    <= up_tag;
            target_mem[up_idx] <= upd_target;
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch-prediction block for the five-stage pipelined RV32I core, placed between the PC register and instruction fetch. In IF it supplies a predicted next PC from a direct-mapped branch target buffer (BTB) plus a 2-bit saturating-counter pattern history table (PHT). When a control-flow instruction resolves in EX, the pipeline drives the update port, which trains the tables, shifts the global history and maintains performance counters. It generalises the core's fixed PC+4 fetch path to configurable depth, history length and indexing mode.

## Interface
- XLEN, 32, datapath and PC width
- ENTRIES, 32, BTB/PHT depth; power of two, 4..1024; IDX = log2(ENTRIES)
- GHR_BITS, 5, global history length; 1..IDX
- MODE, 1, 0 = bimodal (PHT index = PC index), 1 = gshare (PHT index = PC index XOR GHR, GHR zero-extended to IDX)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- if_pc  input  XLEN  PC currently in IF
- pred_taken  output  1  BTB hit and PHT counter MSB = 1
- pred_target  output  XLEN  BTB target of the indexed entry (valid only when hit)
- next_pc  output  XLEN  pred_taken ? pred_target : if_pc + 4
- pred_ghr  output  GHR_BITS  current GHR; pipeline carries it with the instruction to EX
- upd_valid  input  1  resolved branch or jump in EX this cycle
- upd_pc  input  XLEN  PC of the resolved instruction
- upd_taken  input  1  actual direction
- upd_target  input  XLEN  actual taken target
- upd_ghr  input  GHR_BITS  GHR snapshot captured at prediction time
- upd_mispredict  input  1  prediction was wrong (direction or target); qualified by upd_valid
- stat_branches  output  32  resolved-branch count
- stat_misses  output  32  misprediction count

## Operation
- Address split: index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2]; pc[1:0] are ignored.
- Storage per entry: valid (1), tag (XLEN-IDX-2), target (XLEN), and a PHT counter (2 bits). The PHT is indexed separately per MODE.
- Lookup is combinational from registered state. hit = valid[idx] && tag[idx] == if_pc tag.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- On each rising edge with upd_valid = 1:
  - PHT[upd_idx] counts up if upd_taken, down otherwise, saturating at 11 and 00. upd_idx uses upd_ghr, not the live GHR.
  - If upd_taken: BTB[upd_pc index] is written with valid = 1, tag, and upd_target. An existing entry with a different tag is replaced.
  - If not taken: the BTB is untouched. No allocation occurs and no invalidation occurs.
  - GHR becomes {GHR[GHR_BITS-2:0], upd_taken}. When GHR_BITS = 1, GHR = upd_taken.
  - stat_branches increments. stat_misses increments if upd_mispredict. Both saturate at 32'hFFFF_FFFF.
- GHR is non-speculative: it changes only on updates. MODE = 0 ignores GHR for indexing but still maintains it.
- Reset (reset = 0, asynchronous, any time, including mid-update):
  - all valid bits 0
  - all PHT counters 01
  - GHR 0
  - both stat counters 0
- Tag and target arrays need no reset.
- Outputs after reset: pred_taken = 0, next_pc = if_pc + 4, pred_ghr = 0, stats = 0.

## Timing
- Prediction latency is 0 cycles: all prediction outputs are combinational from if_pc and state.
- Update latency is 1 cycle: the table write is visible to a lookup from the edge after upd_valid.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update value. There is no bypass.
- Same-cycle update and reset assertion: reset wins.
- Reset deassertion is synchronous in effect. The first update is accepted on the first rising edge with reset = 1.
- Arithmetic: if_pc + 4 wraps modulo 2^XLEN.
- Counter and stat saturation take priority over increment.

## Test plan
- Reset, then if_pc = 0x0000_0040 -> pred_taken = 0, next_pc = 0x0000_0044, pred_ghr = 0, stat_branches = 0.
- MODE = 0: one update with upd_pc = 0x40, taken, target 0x100 -> next cycle hit, counter 10, pred_taken = 1, next_pc = 0x100. Then two not-taken updates -> counter 00, pred_taken = 0, BTB entry still valid.
- Aliasing, ENTRIES = 32: train 0x40 taken to 0x100, then 0x0C0 (same index, different tag) taken to 0x200 -> lookup 0x40 misses (next_pc = 0x44), lookup 0xC0 gives 0x200.
- MODE = 1, GHR_BITS = 2: updates T, T, N -> pred_ghr = 2'b10. A PHT update with upd_ghr = 2'b11 at upd_pc = 0x40 modifies PHT index 0x10 ^ 0x3 = 0x13 only.
- Counters: 5 updates, 2 with upd_mispredict -> stat_branches = 5, stat_misses = 2. Force stat_misses to 0xFFFF_FFFF, then one more miss -> value stays 0xFFFF_FFFF.
- Assert reset low between clock edges during upd_valid -> outputs immediately return to reset values, and the in-flight update is not applied.
